// File: rtl/operand_stage.sv
// Operand stage: register file, write-pending scoreboard and a one-entry
// operand output register with a valid/ready handshake.
// Optional feature macro: RF_BYPASS_EN -- forwards wb_data straight to a
// source operand when that source is being written back in the same cycle,
// so a pending source does not have to wait for the register file update.
module operand_stage #(
  parameter int DATA_W = 128,
  parameter int NREGS  = 32,
  parameter int IMM_W  = 12,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  input  logic [AW-1:0]     rs3,
  input  logic [AW-1:0]     rd,
  input  logic              rd_we,
  input  logic [IMM_W-1:0]  imm,
  input  logic              imm_sext,
  input  logic [4:0]        round,
  input  logic [1:0]        b_sel,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] c_out,
  output logic [AW-1:0]     op_rd,
  output logic              op_we,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [NREGS-1:0]  busy
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_next;

  logic [DATA_W-1:0] a_src;
  logic [DATA_W-1:0] b_src;
  logic [DATA_W-1:0] c_src;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] imm_ext;
  logic signed [IMM_W-1:0] imm_s;

  logic src1_wait;
  logic src2_wait;
  logic src3_wait;
  logic waw_wait;
  logic hazard;
  logic accept;

`ifdef RF_BYPASS_EN
  logic hit1;
  logic hit2;
  logic hit3;

  // A source matching the current write-back takes wb_data and is not a hazard
  assign hit1 = wb_valid && (wb_rd == rs1);
  assign hit2 = wb_valid && (wb_rd == rs2);
  assign hit3 = wb_valid && (wb_rd == rs3);

  assign a_src = hit1 ? wb_data : regs[rs1];
  assign b_src = hit2 ? wb_data : regs[rs2];
  assign c_src = hit3 ? wb_data : regs[rs3];

  assign src1_wait = busy_q[rs1] && !hit1;
  assign src2_wait = busy_q[rs2] && !hit2;
  assign src3_wait = busy_q[rs3] && !hit3;
`else
  // Sources always come from the register file; a pending source must wait
  assign a_src = regs[rs1];
  assign b_src = regs[rs2];
  assign c_src = regs[rs3];

  assign src1_wait = busy_q[rs1];
  assign src2_wait = busy_q[rs2];
  assign src3_wait = busy_q[rs3];
`endif

  // The destination check is never bypassed: a second writer waits for the first
  assign waw_wait = rd_we && busy_q[rd];
  assign hazard   = src1_wait || src2_wait || src3_wait || waw_wait;

  // The output slot is free when empty or draining this cycle; blocked during reset
  assign iss_ready = !reset && (!op_valid || op_ready) && !hazard;
  assign accept    = iss_valid && iss_ready;

  assign busy = busy_q;

  // A width cast of a signed value sign-extends, which also covers IMM_W == DATA_W
  assign imm_s   = imm;
  assign imm_ext = imm_sext ? DATA_W'(imm_s) : DATA_W'(imm);

  // Select the B operand source
  always_comb begin
    b_val = '0;
    case (b_sel)
      2'd0:    b_val = b_src;
      2'd1:    b_val = imm_ext;
      2'd2:    b_val = DATA_W'(round);
      default: b_val = '0;
    endcase
  end

  // Register file: write-back port, cleared by reset (write-back ignored then)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Scoreboard next state: write-back clears, accept sets, set wins on a tie
  always_comb begin
    busy_next = busy_q;
    if (wb_valid) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (accept && rd_we) begin
      busy_next[rd] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  // Operand output register: load on accept, hold while stalled, empty after handoff
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      c_out    <= '0;
      op_rd    <= '0;
      op_we    <= 1'b0;
    end else if (accept) begin
      op_valid <= 1'b1;
      a_out    <= a_src;
      b_out    <= b_val;
      c_out    <= c_src;
      op_rd    <= rd;
      op_we    <= rd_we;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Testbench for operand_stage: directed scenarios followed by random traffic,
// checked against a behavioural model through an expected-operand queue.
module tb_operand_stage;

  localparam int DATA_W = 128;
  localparam int NREGS  = 32;
  localparam int IMM_W  = 12;
  localparam int AW     = 5;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [AW-1:0]     rd;
    logic              we;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              iss_valid;
  logic              iss_ready;
  logic [AW-1:0]     rs1, rs2, rs3, rd;
  logic              rd_we;
  logic [IMM_W-1:0]  imm;
  logic              imm_sext;
  logic [4:0]        round;
  logic [1:0]        b_sel;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] a_out, b_out, c_out;
  logic [AW-1:0]     op_rd;
  logic              op_we;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [NREGS-1:0]  busy;

  // Reference model state
  logic [DATA_W-1:0] model_r [NREGS];
  logic [NREGS-1:0]  busy_m = '0;
  logic              mv = 1'b0;
  logic              just_reset = 1'b0;
  exp_t              exp_q[$];

  int checks = 0;
  int errors = 0;

  operand_stage #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd), .rd_we(rd_we),
    .imm(imm), .imm_sext(imm_sext), .round(round), .b_sel(b_sel),
    .op_valid(op_valid), .op_ready(op_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .op_rd(op_rd), .op_we(op_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Does the current write-back feed a given source this cycle
  function automatic logic wb_hits(input logic [AW-1:0] r);
`ifdef RF_BYPASS_EN
    return wb_valid && (wb_rd == r);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] read_src(input logic [AW-1:0] r);
    return wb_hits(r) ? wb_data : model_r[r];
  endfunction

  function automatic logic src_blocked(input logic [AW-1:0] r);
    return busy_m[r] && !wb_hits(r);
  endfunction

  function automatic logic exp_ready();
    logic haz;
    haz = src_blocked(rs1) || src_blocked(rs2) || src_blocked(rs3) || (rd_we && busy_m[rd]);
    return !reset && (!mv || op_ready) && !haz;
  endfunction

  function automatic exp_t build_expected();
    exp_t e;
    e.a = read_src(rs1);
    e.c = read_src(rs3);
    case (b_sel)
      2'd0: e.b = read_src(rs2);
      2'd1: begin
        e.b = DATA_W'(imm);
        if (imm_sext && imm[IMM_W-1]) e.b = e.b - (DATA_W'(1) << IMM_W);
      end
      2'd2: e.b = DATA_W'(round);
      default: e.b = '0;
    endcase
    e.rd = rd;
    e.we = rd_we;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Model advances on each clock edge, pushing expected operands on accept
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) model_r[i] <= '0;
      busy_m     <= '0;
      mv         <= 1'b0;
      just_reset <= 1'b1;
      exp_q.delete();
    end else begin
      if (iss_valid && exp_ready()) begin
        exp_q.push_back(build_expected());
        mv         <= 1'b1;
        just_reset <= 1'b0;
      end else if (op_ready) begin
        mv <= 1'b0;
      end
      if (wb_valid) begin
        model_r[wb_rd] <= wb_data;
        busy_m[wb_rd]  <= 1'b0;
      end
      if (iss_valid && exp_ready() && rd_we) busy_m[rd] <= 1'b1;
    end
  end

  // Monitor: compare DUT outputs mid-cycle, retire an op when it is handed off
  always @(negedge clk) begin
    checkOutput("iss_ready", DATA_W'(iss_ready), DATA_W'(exp_ready()));
    checkOutput("busy", DATA_W'(busy), DATA_W'(busy_m));
    checkOutput("op_valid", DATA_W'(op_valid), DATA_W'(mv));
    if (mv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL expect_queue at %0t: got empty expected entry", $time);
      end else begin
        checkOutput("a_out", a_out, exp_q[0].a);
        checkOutput("b_out", b_out, exp_q[0].b);
        checkOutput("c_out", c_out, exp_q[0].c);
        checkOutput("op_rd", DATA_W'(op_rd), DATA_W'(exp_q[0].rd));
        checkOutput("op_we", DATA_W'(op_we), DATA_W'(exp_q[0].we));
        if (op_ready) void'(exp_q.pop_front());
      end
    end else if (just_reset) begin
      checkOutput("reset_a", a_out, '0);
      checkOutput("reset_b", b_out, '0);
      checkOutput("reset_c", c_out, '0);
      checkOutput("reset_rd_we", DATA_W'({op_rd, op_we}), '0);
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic issueOp(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [AW-1:0] r3, input logic [AW-1:0] d,
                         input logic we, input logic [1:0] bs);
    iss_valid = 1'b1;
    rs1 = r1; rs2 = r2; rs3 = r3; rd = d; rd_we = we; b_sel = bs;
  endtask

  function automatic logic [AW-1:0] pick_wb_rd();
    int s;
    s = $urandom_range(0, NREGS - 1);
    if (busy_m != '0 && $urandom_range(0, 99) < 80) begin
      for (int k = 0; k < NREGS; k++) begin
        if (busy_m[(s + k) % NREGS]) return AW'((s + k) % NREGS);
      end
    end
    return AW'(s);
  endfunction

  initial begin
    reset = 1'b1; iss_valid = 1'b0; op_ready = 1'b1;
    rs1 = '0; rs2 = '0; rs3 = '0; rd = '0; rd_we = 1'b0;
    imm = '0; imm_sext = 1'b0; round = '0; b_sel = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);

    // Write R5 then read it with a sign-extended all-ones immediate
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 128'hA5;
    applyStimulus(1);
    wb_valid = 1'b0;
    issueOp(5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 2'd1);
    imm = 12'hFFF; imm_sext = 1'b1; op_ready = 1'b0;
    applyStimulus(1);
    iss_valid = 1'b0;
    applyStimulus(3);
    op_ready = 1'b1;
    issueOp(5'd5, 5'd5, 5'd5, 5'd1, 1'b0, 2'd0);
    applyStimulus(2);
    iss_valid = 1'b0;
    applyStimulus(1);

    // Read-after-write hazard on R3 resolved by a write-back
    issueOp(5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 2'd0);
    applyStimulus(1);
    issueOp(5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 2'd0);
    applyStimulus(2);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 128'h77;
    applyStimulus(1);
    wb_valid = 1'b0;
    applyStimulus(2);
    iss_valid = 1'b0;

    // Accept and write-back to R7 in the same cycle: busy stays set
    issueOp(5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 2'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 128'h1234_5678;
    applyStimulus(1);
    wb_valid = 1'b0;
    issueOp(5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 2'd3);
    applyStimulus(2);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 128'h9;
    applyStimulus(1);
    wb_valid = 1'b0;
    applyStimulus(1);

    // B operand sources: round, zero, zero-extended immediate
    issueOp(5'd1, 5'd2, 5'd4, 5'd0, 1'b0, 2'd2); round = 5'd13;
    applyStimulus(1);
    b_sel = 2'd3;
    applyStimulus(1);
    b_sel = 2'd1; imm = 12'h800; imm_sext = 1'b0;
    applyStimulus(1);
    iss_valid = 1'b0;

    // Reset while an op is held and a write is pending
    issueOp(5'd5, 5'd0, 5'd0, 5'd9, 1'b1, 2'd0); op_ready = 1'b0;
    applyStimulus(1);
    iss_valid = 1'b0; reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0; op_ready = 1'b1;
    issueOp(5'd5, 5'd7, 5'd3, 5'd0, 1'b0, 2'd0);
    applyStimulus(1);
    iss_valid = 1'b0;
    applyStimulus(1);

    // Random traffic over a narrow register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      iss_valid = ($urandom_range(0, 99) < 70);
      op_ready  = ($urandom_range(0, 99) < 70);
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      rs3 = AW'($urandom_range(0, 7)); rd  = AW'($urandom_range(0, 7));
      rd_we = $urandom_range(0, 1) == 1;
      imm = IMM_W'($urandom_range(0, 4095)); imm_sext = $urandom_range(0, 1) == 1;
      round = 5'($urandom_range(0, 31)); b_sel = 2'($urandom_range(0, 3));
      wb_valid = ($urandom_range(0, 99) < 40);
      wb_rd = pick_wb_rd();
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1);
    end

    // Drain: every accepted op must have been presented and retired
    reset = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
    applyStimulus(3);
    checkOutput("queue_drained", DATA_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
